// File: rtl/regfile_pkg.sv
// Shared definitions for the 2-read/1-write register file: sweep FSM encoding
// and default geometry.
package regfile_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } rf_state_t;

   localparam int DEF_W  = 16;
   localparam int DEF_AW = 3;

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: selects a stored word and its busy bit, with an
// optional forward of the in-flight write when addresses match.
module rf_read_port #(
   parameter int W  = 16,
   parameter int AW = 3
) (
   input  logic [AW-1:0]                addr,
   input  logic [(2**AW)-1:0][W-1:0]    regs,
   input  logic [(2**AW)-1:0]           busy_vec,
   input  logic                         byp_en,
   input  logic [AW-1:0]                byp_addr,
   input  logic [W-1:0]                 byp_data,
   output logic [W-1:0]                 data,
   output logic                         busy
);

   always_comb begin
      data = regs[addr];
      if (byp_en && (byp_addr == addr)) begin
         data = byp_data;
      end
   end

   // Busy is never forwarded: a write clears it only once the edge has passed.
   assign busy = busy_vec[addr];

endmodule

// File: rtl/regfile_2r1w.sv
// Register file with one write port, two combinational read ports, a per-entry
// busy scoreboard and a one-entry-per-cycle hardware clear sweep.
module regfile_2r1w
   import regfile_pkg::*;
#(
   parameter int W      = DEF_W,
   parameter int AW     = DEF_AW,
   parameter bit BYPASS = 1'b1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [W-1:0]  data_in,
   input  logic [AW-1:0] writenum,
   input  logic          write,
   input  logic [AW-1:0] readnum_a,
   input  logic [AW-1:0] readnum_b,
   output logic [W-1:0]  data_out_a,
   output logic [W-1:0]  data_out_b,
   input  logic          reserve,
   input  logic [AW-1:0] reservenum,
   output logic          busy_a,
   output logic          busy_b,
   input  logic          clear,
   output logic          sweeping
);

   localparam int N = 2**AW;
   localparam logic [AW-1:0] LAST_IDX = '1;

   logic [N-1:0][W-1:0] regs;
   logic [N-1:0]        busy;
   rf_state_t           state;
   logic [AW-1:0]       idx;
   logic                byp_en;

   // Writes, reservations and clears are only honoured while idle; the sweep
   // owns the array otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regs  <= '0;
         busy  <= '0;
         state <= IDLE;
         idx   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (write) begin
                  regs[writenum] <= data_in;
                  busy[writenum] <= 1'b0;
               end
               // Reserve follows the write so a same-entry reserve wins.
               if (reserve) begin
                  busy[reservenum] <= 1'b1;
               end
               if (clear) begin
                  state <= SWEEP;
                  idx   <= '0;
               end
            end
            SWEEP: begin
               regs[idx] <= '0;
               busy[idx] <= 1'b0;
               idx       <= idx + 1'b1;
               if (idx == LAST_IDX) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign sweeping = (state == SWEEP);
   assign byp_en   = BYPASS && write && (state == IDLE);

   rf_read_port #(.W(W), .AW(AW)) u_port_a (
      .addr     (readnum_a),
      .regs     (regs),
      .busy_vec (busy),
      .byp_en   (byp_en),
      .byp_addr (writenum),
      .byp_data (data_in),
      .data     (data_out_a),
      .busy     (busy_a)
   );

   rf_read_port #(.W(W), .AW(AW)) u_port_b (
      .addr     (readnum_b),
      .regs     (regs),
      .busy_vec (busy),
      .byp_en   (byp_en),
      .byp_addr (writenum),
      .byp_data (data_in),
      .data     (data_out_b),
      .busy     (busy_b)
   );

endmodule

// File: tb/tb_regfile_2r1w.sv
// Bench for regfile_2r1w: directed scenarios with literal expectations plus a
// per-cycle comparison against an array/counter reference model.
module tb_regfile_2r1w;

   localparam int W      = 16;
   localparam int AW     = 3;
   localparam int N      = 8;
   localparam bit BYP    = 1'b1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [W-1:0]  data_in;
   logic [AW-1:0] writenum;
   logic          write;
   logic [AW-1:0] readnum_a;
   logic [AW-1:0] readnum_b;
   logic [W-1:0]  data_out_a;
   logic [W-1:0]  data_out_b;
   logic          reserve;
   logic [AW-1:0] reservenum;
   logic          busy_a;
   logic          busy_b;
   logic          clear;
   logic          sweeping;

   int checks   = 0;
   int failures = 0;
   bit check_en = 1'b0;

   // Reference state: stored words, busy flags, and how many sweep edges remain.
   bit [W-1:0] mdl_reg [N];
   bit         mdl_busy[N];
   int         sweep_left = 0;

   regfile_2r1w #(.W(W), .AW(AW), .BYPASS(BYP)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .data_in    (data_in),
      .writenum   (writenum),
      .write      (write),
      .readnum_a  (readnum_a),
      .readnum_b  (readnum_b),
      .data_out_a (data_out_a),
      .data_out_b (data_out_b),
      .reserve    (reserve),
      .reservenum (reservenum),
      .busy_a     (busy_a),
      .busy_b     (busy_b),
      .clear      (clear),
      .sweeping   (sweeping)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) begin
            mdl_reg[i]  = '0;
            mdl_busy[i] = 1'b0;
         end
         sweep_left = 0;
      end else if (sweep_left > 0) begin
         mdl_reg[N - sweep_left]  = '0;
         mdl_busy[N - sweep_left] = 1'b0;
         sweep_left--;
      end else begin
         if (write) begin
            mdl_reg[writenum]  = data_in;
            mdl_busy[writenum] = 1'b0;
         end
         if (reserve) mdl_busy[reservenum] = 1'b1;
         if (clear) sweep_left = N;
      end
   end

   function automatic logic [W-1:0] exp_read(input logic [AW-1:0] ra);
      if (BYP && write && (sweep_left == 0) && (writenum == ra)) return data_in;
      return mdl_reg[ra];
   endfunction

   always @(negedge clk) begin
      if (check_en) begin
         chk("mdl_data_a", data_out_a, exp_read(readnum_a));
         chk("mdl_data_b", data_out_b, exp_read(readnum_b));
         chk("mdl_busy_a", busy_a, mdl_busy[readnum_a]);
         chk("mdl_busy_b", busy_b, mdl_busy[readnum_b]);
         chk("mdl_sweeping", sweeping, sweep_left != 0);
      end
   end

   // Advance to 2 time units after the next rising edge and drop one-shot controls.
   task automatic step();
      @(posedge clk);
      #2;
      write   = 1'b0;
      reserve = 1'b0;
      clear   = 1'b0;
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [W-1:0] d);
      write = 1'b1; writenum = a; data_in = d;
      step();
   endtask

   initial begin
      rst_n = 1'b0;
      data_in = '0; writenum = '0; write = 1'b0;
      readnum_a = '0; readnum_b = '0;
      reserve = 1'b0; reservenum = '0; clear = 1'b0;
      @(posedge clk);
      #2 check_en = 1'b1;
      step();
      rst_n = 1'b1;
      step();

      for (int i = 0; i < N; i++) begin
         readnum_a = AW'(i); readnum_b = AW'(N - 1 - i);
         #1;
         chk("rst_data_a", data_out_a, 16'h0000);
         chk("rst_data_b", data_out_b, 16'h0000);
         chk("rst_busy_a", busy_a, 1'b0);
         chk("rst_sweeping", sweeping, 1'b0);
         step();
      end

      write = 1'b1; writenum = 3'd3; data_in = 16'hABCD; readnum_a = 3'd3;
      #1 chk("bypass_same_cycle", data_out_a, 16'hABCD);
      step();
      #1 chk("write_stored", data_out_a, 16'hABCD);

      reserve = 1'b1; reservenum = 3'd5; readnum_a = 3'd5;
      #1 chk("busy_not_bypassed", busy_a, 1'b0);
      step();
      #1 chk("reserve_busy", busy_a, 1'b1);
      write = 1'b1; writenum = 3'd5; data_in = 16'h0042;
      #1 chk("busy_until_edge", busy_a, 1'b1);
      step();
      #1 chk("write_clears_busy", busy_a, 1'b0);
      chk("r5_data", data_out_a, 16'h0042);
      write = 1'b1; writenum = 3'd6; data_in = 16'h0042;
      reserve = 1'b1; reservenum = 3'd6;
      step();
      readnum_a = 3'd6;
      #1 chk("resv_write_data", data_out_a, 16'h0042);
      chk("resv_write_busy", busy_a, 1'b1);

      for (int i = 0; i < N; i++) do_write(AW'(i), W'(i + 1));
      clear = 1'b1;
      step();
      for (int k = 0; k < N; k++) begin
         if (k == 3) begin
            readnum_a = 3'd2; readnum_b = 3'd6;
            #1 chk("mid_sweep_r2", data_out_a, 16'h0000);
            chk("mid_sweep_r6", data_out_b, 16'h0007);
         end
         if (k == 4) begin
            write = 1'b1; writenum = 3'd7; data_in = 16'h0099; readnum_b = 3'd7;
            #1 chk("sweep_no_bypass", data_out_b, 16'h0008);
         end
         #1 chk("sweeping_high", sweeping, 1'b1);
         step();
      end
      #1 chk("sweeping_fell", sweeping, 1'b0);
      for (int i = 0; i < N; i++) begin
         readnum_a = AW'(i); readnum_b = AW'(i);
         #1 chk("post_sweep_zero", data_out_a, 16'h0000);
         step();
      end

      for (int i = 0; i < N; i++) do_write(AW'(i), W'(16'h0010 + i));
      clear = 1'b1;
      step();
      step(); step(); step();
      rst_n = 1'b0;
      readnum_a = 3'd5;
      #1 chk("rst_mid_sweep_fall", sweeping, 1'b0);
      chk("rst_mid_sweep_data", data_out_a, 16'h0000);
      step();
      rst_n = 1'b1;
      write = 1'b1; writenum = 3'd4; data_in = 16'h1234; readnum_a = 3'd4;
      step();
      #1 chk("write_after_release", data_out_a, 16'h1234);

      for (int c = 0; c < 1000; c++) begin
         write      = ($urandom_range(0, 2) != 0);
         writenum   = AW'($urandom_range(0, N - 1));
         data_in    = W'($urandom);
         reserve    = ($urandom_range(0, 3) == 0);
         reservenum = AW'($urandom_range(0, N - 1));
         clear      = ($urandom_range(0, 63) == 0);
         readnum_a  = AW'($urandom_range(0, N - 1));
         readnum_b  = ($urandom_range(0, 3) == 0) ? readnum_a : AW'($urandom_range(0, N - 1));
         if ($urandom_range(0, 4) == 0) readnum_a = writenum;
         @(posedge clk);
         #2;
      end
      write = 1'b0; reserve = 1'b0; clear = 1'b0;
      step();
      check_en = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
